neuron_backprop: RTL and testbench

- Backward-pass companion to the forward neuron: given the error delta at the neuron output, streams all N_INPUTS (input activation, weight) pairs and emits, per element, the SGD-updated weight and the gradient propagated back to that input.
- Sits between the weight memory reader and the weight memory writer/previous-layer error accumulator.
- Handles one neuron per run: start, N_INPUTS beats, done pulse.

---
 rtl/neuron_backprop.sv | 129 ++++++++++++
 tb/tb_neuron_backprop.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_backprop.sv
// Backward pass for one neuron: streams (activation, weight) pairs and emits the
// SGD-updated weight plus the gradient propagated back to each input.
module neuron_backprop #(
  parameter int unsigned N_INPUTS = 784,
  parameter int unsigned LR_SHIFT = 8,
  parameter int unsigned IDX_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [15:0]      delta,
  input  logic        [7:0]       out_act,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [7:0]       x_in,
  input  logic signed [15:0]      w_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      w_out,
  output logic signed [15:0]      g_out,
  output logic        [IDX_W-1:0] idx_out,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_e                   state_q, state_d;
  logic signed [15:0]       delta_q, delta_d;
  logic        [IDX_W-1:0]  cnt_q, cnt_d;
  logic        [IDX_W-1:0]  idx_q, idx_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [15:0]       w_q, w_d;
  logic signed [15:0]       g_q, g_d;

  logic                     in_acc, out_acc, last_beat;
  logic signed [24:0]       prod_p, step_s;
  logic signed [25:0]       w_diff;
  logic signed [31:0]       prod_q;
  logic signed [16:0]       g_shift;
  logic signed [15:0]       w_sat, g_sat;

  // Datapath: weight step and back-propagated gradient, both saturated to s16.
  always_comb begin
    prod_p  = delta_q * $signed({1'b0, x_in});
    step_s  = prod_p >>> LR_SHIFT;
    w_diff  = w_in - step_s;
    prod_q  = delta_q * w_in;
    g_shift = 17'(prod_q >>> 15);

    if (w_diff > 26'sd32767)       w_sat = 16'sh7fff;
    else if (w_diff < -26'sd32768) w_sat = 16'sh8000;
    else                           w_sat = w_diff[15:0];

    if (g_shift > 17'sd32767)      g_sat = 16'sh7fff;
    else                           g_sat = g_shift[15:0];
  end

  assign in_ready  = (state_q == S_RUN) & (~out_valid_q | out_ready);
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid_q & out_ready;
  assign last_beat = (cnt_q == LAST_IDX);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) & out_acc;
  assign out_valid = out_valid_q;
  assign w_out     = w_q;
  assign g_out     = g_q;
  assign idx_out   = idx_q;

  always_comb begin
    state_d     = state_q;
    delta_d     = delta_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    w_d         = w_q;
    g_d         = g_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          // Saturated forward output means zero derivative, so nothing propagates.
          delta_d = (out_act == 8'd0 || out_act == 8'hff) ? '0 : delta;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (in_acc && last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (out_acc) out_valid_d = 1'b0;
    if (in_acc) begin
      out_valid_d = 1'b1;
      idx_d       = cnt_q;
      w_d         = w_sat;
      g_d         = g_sat;
      if (!last_beat) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      delta_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      w_q         <= '0;
      g_q         <= '0;
    end else begin
      state_q     <= state_d;
      delta_q     <= delta_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      w_q         <= w_d;
      g_q         <= g_d;
    end
  end

endmodule

// File: tb/tb_neuron_backprop.sv
// Randomized bench for neuron_backprop: arithmetic reference model plus an
// in-order queue of expected output beats.
module tb_neuron_backprop;

  localparam int unsigned N  = 784;
  localparam int unsigned LR = 8;
  localparam int unsigned IW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic signed [15:0]   delta;
  logic        [7:0]    out_act;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic        [7:0]    x_in;
  logic signed [15:0]   w_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [15:0]   w_out;
  logic signed [15:0]   g_out;
  logic        [IW-1:0] idx_out;
  logic                 done;

  typedef struct {
    int idx;
    int w;
    int g;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  neuron_backprop #(.N_INPUTS(N), .LR_SHIFT(LR), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delta(delta), .out_act(out_act),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready), .w_out(w_out),
    .g_out(g_out), .idx_out(idx_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint num, input longint den);
    longint r;
    r = num / den;
    if (num < 0 && (num % den) != 0) r = r - 1;
    return r;
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t ref_beat(input int de, input int x, input int w, input int i);
    exp_t e;
    longint step;
    step  = floor_div(longint'(de) * x, longint'(1) << LR);
    e.idx = i;
    e.w   = int'(clamp16(longint'(w) - step));
    e.g   = int'(clamp16(floor_div(longint'(de) * w, 32768)));
    return e;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  {47'h0, busy},      48'h0);
    check({tag, "_rdy"},   {47'h0, in_ready},  48'h0);
    check({tag, "_ovld"},  {47'h0, out_valid}, 48'h0);
    check({tag, "_done"},  {47'h0, done},      48'h0);
    check({tag, "_data"},  {16'(idx_out), w_out, g_out}, 48'h0);
  endtask

  // rmode: 0 = always ready / always valid, 1 = random handshakes, 2 = 5-cycle stall
  task automatic run_neuron(input logic signed [15:0] d, input logic [7:0] a,
                            input bit fixed, input logic [7:0] fx, input logic signed [15:0] fw,
                            input bit chk_fixed, input logic signed [15:0] cw,
                            input logic signed [15:0] cg, input int rmode,
                            input bit mid_start, input int abort_at);
    exp_t q[$];
    exp_t e;
    int n_in, n_out, cyc, first_acc, done_cyc, de;
    bit exp_rdy, acc_in, acc_out, exp_done;

    de = (a == 8'd0 || a == 8'd255) ? 0 : int'(d);
    @(negedge clk);
    start = 1'b1; delta = d; out_act = a; in_valid = 1'b0; out_ready = 1'b0;
    n_in = 0; n_out = 0; cyc = 0; first_acc = -1; done_cyc = -1;
    while (n_out < int'(N) && cyc < 20000) begin
      @(negedge clk);
      if (abort_at >= 0 && n_in >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; start = 1'b0;
        return;
      end
      start    = mid_start && (cyc == 50);
      delta    = 16'($urandom);
      out_act  = 8'($urandom_range(1, 254));
      x_in     = fixed ? fx : 8'($urandom);
      w_in     = fixed ? fw : 16'($urandom);
      case (rmode)
        0: begin in_valid = 1'b1; out_ready = 1'b1; end
        1: begin in_valid = ($urandom_range(0, 3) != 0); out_ready = 1'($urandom_range(0, 1)); end
        default: begin in_valid = 1'b1; out_ready = !(cyc >= 10 && cyc < 15); end
      endcase
      #1;
      exp_rdy  = (n_in < int'(N)) && (q.size() == 0 || out_ready);
      acc_in   = in_valid && exp_rdy;
      acc_out  = (q.size() != 0) && out_ready;
      exp_done = acc_out && (q[0].idx == int'(N) - 1);
      check("busy",      {47'h0, busy},      48'h1);
      check("in_ready",  {47'h0, in_ready},  {47'h0, exp_rdy});
      check("out_valid", {47'h0, out_valid}, {47'h0, q.size() != 0});
      check("done",      {47'h0, done},      {47'h0, exp_done});
      if (q.size() != 0)
        check("beat", {16'(idx_out), w_out, g_out}, {16'(q[0].idx), 16'(q[0].w), 16'(q[0].g)});
      if (acc_out) begin
        if (chk_fixed) check("known_value", {16'h0, w_out, g_out}, {16'h0, cw, cg});
        void'(q.pop_front());
        n_out++;
        if (exp_done) done_cyc = cyc;
      end
      if (acc_in) begin
        e = ref_beat(de, int'(x_in), int'(w_in), n_in);
        q.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        n_in++;
      end
      cyc++;
    end
    check("beats_out", 48'(n_out), 48'(N));
    if (rmode == 0) check("done_latency_ok", {47'h0, (done_cyc - first_acc) <= 785}, 48'h1);
    @(negedge clk);
    in_valid = 1'b1; start = 1'b0; out_ready = 1'b1;
    #1;
    check("post_busy", {47'h0, busy},     48'h0);
    check("post_rdy",  {47'h0, in_ready}, 48'h0);
    check("post_done", {47'h0, done},     48'h0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; delta = '0; out_act = '0; in_valid = 1'b0;
    x_in = '0; w_in = '0; out_ready = 1'b0;
    #1;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("idle_rdy", {47'h0, in_ready}, 48'h0);

    run_neuron(16'sd256, 8'd100, 1'b1, 8'd2, 16'sd1000, 1'b1, 16'sd998, 16'sd7, 0, 1'b0, -1);
    run_neuron(16'($urandom), 8'd77, 1'b0, 8'd0, 16'sd0, 1'b0, 16'sd0, 16'sd0, 1, 1'b1, -1);
    run_neuron(-16'sd32768, 8'd50, 1'b1, 8'd255, 16'sd32767, 1'b1, 16'sd32767, -16'sd32767, 0, 1'b0, -1);
    run_neuron(-16'sd32768, 8'd50, 1'b1, 8'd255, -16'sd32768, 1'b1, -16'sd128, 16'sd32767, 1, 1'b0, -1);
    run_neuron(16'sd1000, 8'd255, 1'b1, 8'd200, -16'sd500, 1'b1, -16'sd500, 16'sd0, 0, 1'b0, -1);
    run_neuron(16'sd1000, 8'd0, 1'b1, 8'd200, -16'sd500, 1'b1, -16'sd500, 16'sd0, 1, 1'b0, -1);
    run_neuron(-16'sd1, 8'd10, 1'b1, 8'd1, 16'sd0, 1'b1, 16'sd1, 16'sd0, 0, 1'b0, -1);
    run_neuron(16'($urandom), 8'd128, 1'b0, 8'd0, 16'sd0, 1'b0, 16'sd0, 16'sd0, 2, 1'b0, -1);
    run_neuron(16'sd4000, 8'd30, 1'b0, 8'd0, 16'sd0, 1'b0, 16'sd0, 16'sd0, 1, 1'b0, 300);
    run_neuron(-16'sd12345, 8'd200, 1'b0, 8'd0, 16'sd0, 1'b0, 16'sd0, 16'sd0, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
